// File: rtl/fpu_add_arb_if.sv
// rtl/fpu_add_arb_if.sv - requester, FPU and response signal bundle for fpu_add_arb
// Purpose: groups both requester handshakes, the FPU issue/result path and the
//          response/status outputs of fpu_add_arb.
// Modports:
//   slave  - the arbiter: takes requests, flush, rmode and fpu_ro; drives
//            grants, fpu_* issue signals, responses and inflight.
//   master - the surrounding logic (requesters, FPU, response consumer).
`timescale 1ns/1ps
interface fpu_add_arb_if;
    logic        reqa_valid;
    logic        reqa_ready;
    logic [3:0]  reqa_op;
    logic [63:0] reqa_rn;
    logic [63:0] reqa_rm;
    logic [3:0]  reqa_tag;
    logic        reqb_valid;
    logic        reqb_ready;
    logic [3:0]  reqb_op;
    logic [63:0] reqb_rn;
    logic [63:0] reqb_rm;
    logic [3:0]  reqb_tag;
    logic [7:0]  rmode;
    logic        flush;
    logic [63:0] fpu_rn;
    logic [63:0] fpu_rm;
    logic [3:0]  fpu_op;
    logic [7:0]  fpu_rmode;
    logic        fpu_hold;
    logic [63:0] fpu_ro;
    logic        resp_valid;
    logic        resp_port;
    logic [3:0]  resp_tag;
    logic [63:0] resp_val;
    logic [2:0]  inflight;

    modport slave (
        input  reqa_valid, reqa_op, reqa_rn, reqa_rm, reqa_tag,
        input  reqb_valid, reqb_op, reqb_rn, reqb_rm, reqb_tag,
        input  rmode, flush, fpu_ro,
        output reqa_ready, reqb_ready,
        output fpu_rn, fpu_rm, fpu_op, fpu_rmode, fpu_hold,
        output resp_valid, resp_port, resp_tag, resp_val, inflight
    );

    modport master (
        output reqa_valid, reqa_op, reqa_rn, reqa_rm, reqa_tag,
        output reqb_valid, reqb_op, reqb_rn, reqb_rm, reqb_tag,
        output rmode, flush, fpu_ro,
        input  reqa_ready, reqb_ready,
        input  fpu_rn, fpu_rm, fpu_op, fpu_rmode, fpu_hold,
        input  resp_valid, resp_port, resp_tag, resp_val, inflight
    );
endinterface

// File: rtl/fpu_add_arb.sv
// rtl/fpu_add_arb.sv - two-requester arbiter in front of a fixed-latency FPU adder
// Purpose: grants one of two requesters per cycle onto a pipelined FPU add unit,
//          tracks {valid, port, tag} of each issued op in a LATENCY-deep shift
//          register and returns the FPU result to the issuing requester.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - fpu_add_arb_if.slave (requests, grants, FPU issue/result, responses)
// Configuration:
//   FPU_ADD_ARB_RR_EN - when defined, contention is resolved by a round-robin
//                       pointer; otherwise requester A always wins.
`timescale 1ns/1ps
module fpu_add_arb #(
    parameter int LATENCY = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    fpu_add_arb_if.slave  bus
);

    typedef struct packed {
        logic       valid;
        logic       port;
        logic [3:0] tag;
    } slot_t;

    slot_t [LATENCY-1:0] pipe_q;
    slot_t [LATENCY-1:0] pipe_d;
    logic [2:0]          inflight_q;
    logic [2:0]          inflight_d;
`ifdef FPU_ADD_ARB_RR_EN
    logic                ptr_q;
    logic                ptr_d;
`endif

    logic       grant_a;
    logic       grant_b;
    logic       issue;
    logic       push_valid;
    logic       resp_valid;
    logic [3:0] sel_op;
    logic [3:0] sel_tag;

    // Grants are gated by rst_n so both readys read 0 during reset even with
    // requests pending.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n && !bus.flush) begin
            if (bus.reqa_valid && bus.reqb_valid) begin
`ifdef FPU_ADD_ARB_RR_EN
                grant_a = !ptr_q;
                grant_b = ptr_q;
`else
                grant_a = 1'b1;
`endif
            end else begin
                grant_a = bus.reqa_valid;
                grant_b = bus.reqb_valid;
            end
        end
    end

    assign issue = grant_a | grant_b;

    always_comb begin
        sel_op     = 4'd0;
        sel_tag    = 4'd0;
        bus.fpu_rn = 64'd0;
        bus.fpu_rm = 64'd0;
        if (grant_b) begin
            sel_op     = bus.reqb_op;
            sel_tag    = bus.reqb_tag;
            bus.fpu_rn = bus.reqb_rn;
            bus.fpu_rm = bus.reqb_rm;
        end else if (grant_a) begin
            sel_op     = bus.reqa_op;
            sel_tag    = bus.reqa_tag;
            bus.fpu_rn = bus.reqa_rn;
            bus.fpu_rm = bus.reqa_rm;
        end
    end

    // Only opcodes 1..4 (low three bits) produce a result; others are
    // accepted but tracked as an empty slot.
    assign push_valid = issue && (sel_op[2:0] != 3'd0) && (sel_op[2:0] <= 3'd4);
    assign resp_valid = pipe_q[LATENCY-1].valid;

    always_comb begin
        pipe_d[0].valid = push_valid;
        pipe_d[0].port  = grant_b;
        pipe_d[0].tag   = sel_tag;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        if (bus.flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_d[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (bus.flush) begin
            inflight_d = 3'd0;
        end else if (push_valid && !resp_valid) begin
            inflight_d = inflight_q + 3'd1;
        end else if (!push_valid && resp_valid) begin
            inflight_d = inflight_q - 3'd1;
        end
    end

`ifdef FPU_ADD_ARB_RR_EN
    // Pointer flips on every issue, including null ops and uncontended grants.
    assign ptr_d = issue ? !ptr_q : ptr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q     <= '0;
            inflight_q <= 3'd0;
`ifdef FPU_ADD_ARB_RR_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            pipe_q     <= pipe_d;
            inflight_q <= inflight_d;
`ifdef FPU_ADD_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign bus.reqa_ready = grant_a;
    assign bus.reqb_ready = grant_b;
    assign bus.fpu_op     = sel_op;
    assign bus.fpu_rmode  = bus.rmode;
    assign bus.fpu_hold   = 1'b0;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_port  = resp_valid & pipe_q[LATENCY-1].port;
    assign bus.resp_tag   = resp_valid ? pipe_q[LATENCY-1].tag : 4'd0;
    assign bus.resp_val   = bus.fpu_ro;
    assign bus.inflight   = inflight_q;

endmodule

// File: tb/tb_fpu_add_arb.sv
// tb/tb_fpu_add_arb.sv - self-checking bench for fpu_add_arb
`timescale 1ns/1ps
module tb_fpu_add_arb;
    localparam int LAT = 5;

    logic clk;
    logic rst_n;
    fpu_add_arb_if bus();

    fpu_add_arb #(.LATENCY(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] fp_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        integer iv;
        case (op[2:0])
            3'd1: return $realtobits($bitstoreal(a) + $bitstoreal(b));
            3'd2: return $realtobits($bitstoreal(a) - $bitstoreal(b));
            3'd3: return $realtobits(real'($signed(a)));
            3'd4: begin
                iv = $rtoi($bitstoreal(a));
                return {{32{iv[31]}}, iv};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Stand-in FPU: result of whatever is on fpu_* at an edge emerges LAT cycles later.
    logic [LAT-1:0][63:0] fpu_pipe;
    always @(posedge clk) begin
        fpu_pipe <= {fpu_pipe[LAT-2:0], fp_ref(bus.fpu_op, bus.fpu_rn, bus.fpu_rm)};
    end
    assign bus.fpu_ro = fpu_pipe[LAT-1];

    typedef struct {
        int          due;
        bit          port;
        logic [3:0]  tag;
        logic [63:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   issues;
    int   n_cmp;
    int   n_bad;

    logic        s_ra, s_rb, s_rv, s_port;
    logic [3:0]  s_tag;
    logic [63:0] s_val;
    logic [2:0]  s_inflight;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.reqa_valid = 0; bus.reqa_op = 0; bus.reqa_rn = 0; bus.reqa_rm = 0; bus.reqa_tag = 0;
        bus.reqb_valid = 0; bus.reqb_op = 0; bus.reqb_rn = 0; bus.reqb_rm = 0; bus.reqb_tag = 0;
        bus.flush = 0;
    endtask

    // Checks one cycle against the model at the falling edge, then advances.
    task automatic cycle();
        bit ea, eb;
        logic [3:0]  op, tag;
        logic [63:0] rn, rm;
        exp_t e;
        @(negedge clk);
        s_ra = bus.reqa_ready; s_rb = bus.reqb_ready; s_rv = bus.resp_valid;
        s_port = bus.resp_port; s_tag = bus.resp_tag; s_val = bus.resp_val; s_inflight = bus.inflight;
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        chk("inflight", {61'd0, bus.inflight}, 64'(q.size()));
        chk("fpu_rmode", {56'd0, bus.fpu_rmode}, {56'd0, bus.rmode});
        chk("fpu_hold", {63'd0, bus.fpu_hold}, 64'd0);
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("resp_valid", {63'd0, bus.resp_valid}, 64'd1);
            chk("resp_port", {63'd0, bus.resp_port}, {63'd0, q[0].port});
            chk("resp_tag", {60'd0, bus.resp_tag}, {60'd0, q[0].tag});
            chk("resp_val", bus.resp_val, q[0].val);
        end else begin
            chk("resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        end
        ea = 0; eb = 0;
        if (!bus.flush) begin
            if (bus.reqa_valid && bus.reqb_valid) begin
`ifdef FPU_ADD_ARB_RR_EN
                if (issues % 2 == 1) eb = 1; else ea = 1;
`else
                ea = 1;
`endif
            end else begin
                ea = bus.reqa_valid;
                eb = bus.reqb_valid;
            end
        end
        chk("reqa_ready", {63'd0, bus.reqa_ready}, {63'd0, ea});
        chk("reqb_ready", {63'd0, bus.reqb_ready}, {63'd0, eb});
        if (ea || eb) begin
            op  = eb ? bus.reqb_op  : bus.reqa_op;
            tag = eb ? bus.reqb_tag : bus.reqa_tag;
            rn  = eb ? bus.reqb_rn  : bus.reqa_rn;
            rm  = eb ? bus.reqb_rm  : bus.reqa_rm;
            chk("fpu_op", {60'd0, bus.fpu_op}, {60'd0, op});
            chk("fpu_rn", bus.fpu_rn, rn);
            chk("fpu_rm", bus.fpu_rm, rm);
            issues++;
            if (op[2:0] >= 1 && op[2:0] <= 4) begin
                e.due = cyc + LAT; e.port = eb; e.tag = tag; e.val = fp_ref(op, rn, rm);
                q.push_back(e);
            end
        end else begin
            chk("fpu_op_idle", {60'd0, bus.fpu_op}, 64'd0);
        end
        if (bus.flush) q.delete();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Asserts reset 1 time unit after an edge, leaving current inputs applied.
    task automatic do_reset();
        rst_n = 0;
        #2;
        chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("rst_resp_port", {63'd0, bus.resp_port}, 64'd0);
        chk("rst_resp_tag", {60'd0, bus.resp_tag}, 64'd0);
        chk("rst_inflight", {61'd0, bus.inflight}, 64'd0);
        chk("rst_reqa_ready", {63'd0, bus.reqa_ready}, 64'd0);
        chk("rst_reqb_ready", {63'd0, bus.reqb_ready}, 64'd0);
        chk("rst_fpu_op", {60'd0, bus.fpu_op}, 64'd0);
        set_idle();
        q.delete();
        issues = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        cyc += 2;
    endtask

    typedef struct {
        bit         av, bv, fl;
        logic [3:0] aop, bop;
        bit         ea, eb;
        logic [3:0] eop;
    } row_t;

    row_t tbl[8];
    int   lat, cnt;
    bit   exp_b[4];
    bit   got_b[4];
    bit   ports[$];

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; issues = 0;
        bus.rmode = 8'h3;
        set_idle();
        do_reset();

        // Combinational grant table, pointer at reset value; inputs withdrawn before each edge.
        tbl[0] = '{0, 0, 0, 4'd1, 4'd2, 0, 0, 4'd0};
        tbl[1] = '{1, 0, 0, 4'd1, 4'd2, 1, 0, 4'd1};
        tbl[2] = '{0, 1, 0, 4'd1, 4'd2, 0, 1, 4'd2};
        tbl[3] = '{1, 1, 0, 4'd3, 4'd4, 1, 0, 4'd3};
        tbl[4] = '{1, 1, 1, 4'd3, 4'd4, 0, 0, 4'd0};
        tbl[5] = '{0, 1, 0, 4'd0, 4'd0, 0, 1, 4'd0};
        tbl[6] = '{1, 0, 0, 4'd9, 4'd0, 1, 0, 4'd9};
        tbl[7] = '{1, 0, 1, 4'd1, 4'd0, 0, 0, 4'd0};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus.reqa_valid = tbl[i].av; bus.reqb_valid = tbl[i].bv; bus.flush = tbl[i].fl;
            bus.reqa_op = tbl[i].aop; bus.reqb_op = tbl[i].bop;
            bus.reqa_rn = 64'hA; bus.reqb_rn = 64'hB;
            #1;
            chk("tbl_reqa_ready", {63'd0, bus.reqa_ready}, {63'd0, tbl[i].ea});
            chk("tbl_reqb_ready", {63'd0, bus.reqb_ready}, {63'd0, tbl[i].eb});
            chk("tbl_fpu_op", {60'd0, bus.fpu_op}, {60'd0, tbl[i].eop});
            chk("tbl_fpu_rn", bus.fpu_rn, tbl[i].ea ? 64'hA : (tbl[i].eb ? 64'hB : 64'h0));
            #1;
            set_idle();
        end
        @(posedge clk); #1;
        do_reset();

        // Single add: 1.0 + 2.0 from A, tag 3.
        bus.reqa_valid = 1; bus.reqa_op = 4'd1; bus.reqa_tag = 4'd3;
        bus.reqa_rn = 64'h3FF0000000000000; bus.reqa_rm = 64'h4000000000000000;
        cycle();
        set_idle();
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (s_rv && lat < 0) begin
                lat = i;
                chk("single_port", {63'd0, s_port}, 64'd0);
                chk("single_tag", {60'd0, s_tag}, 64'd3);
                chk("single_val", s_val, 64'h4008000000000000);
            end
        end
        chk("single_latency", 64'(lat), 64'(LAT));

        // Contention: both requesters valid for 4 cycles.
        do_reset();
`ifdef FPU_ADD_ARB_RR_EN
        exp_b = '{0, 1, 0, 1};
`else
        exp_b = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            bus.reqa_valid = 1; bus.reqa_op = 4'd1; bus.reqa_tag = 4'(i);
            bus.reqa_rn = $realtobits(real'(i)); bus.reqa_rm = $realtobits(1.0);
            bus.reqb_valid = 1; bus.reqb_op = 4'd2; bus.reqb_tag = 4'(i + 8);
            bus.reqb_rn = $realtobits(10.0); bus.reqb_rm = $realtobits(real'(i));
            cycle();
            got_b[i] = s_rb;
            chk("contend_grant_b", {63'd0, got_b[i]}, {63'd0, exp_b[i]});
        end
        set_idle();
        ports.delete();
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_rv) ports.push_back(s_port);
        end
        chk("contend_resp_count", 64'(ports.size()), 64'd4);
        for (int i = 0; i < 4 && i < ports.size(); i++)
            chk("contend_resp_order", {63'd0, ports[i]}, {63'd0, exp_b[i]});

        // Flush after three issues; op issued right after flush still returns.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.reqa_valid = 1; bus.reqa_op = 4'd2; bus.reqa_tag = 4'(i);
            bus.reqa_rn = $realtobits(5.0); bus.reqa_rm = $realtobits(1.5);
            cycle();
        end
        bus.flush = 1;
        cycle();
        chk("flush_no_grant", {63'd0, s_ra}, 64'd0);
        bus.flush = 0; bus.reqa_tag = 4'd9;
        cycle();
        chk("flush_inflight", {61'd0, s_inflight}, 64'd0);
        set_idle();
        cnt = 0; lat = -1;
        for (int i = 1; i <= 9; i++) begin
            cycle();
            if (s_rv) begin
                cnt++;
                lat = i;
                chk("flush_tag", {60'd0, s_tag}, 64'd9);
            end
        end
        chk("flush_resp_count", 64'(cnt), 64'd1);
        chk("flush_latency", 64'(lat), 64'(LAT));

        // Null op from B.
        bus.reqb_valid = 1; bus.reqb_op = 4'd0; bus.reqb_tag = 4'd5;
        cycle();
        chk("null_ready", {63'd0, s_rb}, 64'd1);
        set_idle();
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            cycle();
            if (i == 0) chk("null_inflight", {61'd0, s_inflight}, 64'd0);
            if (s_rv) cnt++;
        end
        chk("null_resp_count", 64'(cnt), 64'd0);

        // Reset with four ops in flight.
        for (int i = 0; i < 4; i++) begin
            bus.reqa_valid = 1; bus.reqa_op = 4'd1; bus.reqa_tag = 4'(i);
            bus.reqa_rn = $realtobits(1.0); bus.reqa_rm = $realtobits(1.0);
            cycle();
        end
        bus.reqb_valid = 1; bus.reqb_op = 4'd1;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_rv) cnt++;
        end
        chk("post_reset_no_resp", 64'(cnt), 64'd0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            bus.rmode = 8'($urandom);
            bus.flush = ($urandom_range(0, 99) < 5);
            bus.reqa_valid = ($urandom_range(0, 99) < 60);
            bus.reqb_valid = ($urandom_range(0, 99) < 60);
            bus.reqa_op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
            bus.reqb_op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
            bus.reqa_tag = 4'($urandom); bus.reqb_tag = 4'($urandom);
            bus.reqa_rn = $realtobits(real'($urandom_range(0, 1000)) - 500.0);
            bus.reqa_rm = $realtobits(real'($urandom_range(0, 1000)) / 4.0);
            bus.reqb_rn = $realtobits(real'($urandom_range(0, 1000)) - 250.0);
            bus.reqb_rm = $realtobits(real'($urandom_range(0, 1000)) / 8.0);
            cycle();
        end
        set_idle();
        for (int i = 0; i < LAT + 2; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
